// File: rtl/vm_pkg.sv
// vm_pkg: shared encodings for the vending front end.
//   Denomination codes and values, item codes and default prices, FSM state constants.
package vm_pkg;

    localparam logic [1:0] COIN_1  = 2'd0;
    localparam logic [1:0] COIN_5  = 2'd1;
    localparam logic [1:0] COIN_10 = 2'd2;
    localparam logic [1:0] COIN_20 = 2'd3;

    localparam logic [1:0] ITEM_NONE  = 2'd0;
    localparam logic [1:0] ITEM_CANDY = 2'd1;
    localparam logic [1:0] ITEM_DRINK = 2'd2;
    localparam logic [1:0] ITEM_SNACK = 2'd3;

    localparam int PRICE_CANDY_DEF = 15;
    localparam int PRICE_DRINK_DEF = 30;
    localparam int PRICE_SNACK_DEF = 60;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_CHANGE = 1'b1;

    function automatic logic [4:0] coin_value(input logic [1:0] t);
        return t == COIN_20 ? 5'd20 : t == COIN_10 ? 5'd10 : t == COIN_5 ? 5'd5 : 5'd1;
    endfunction

endpackage

// File: rtl/change_picker.sv
// change_picker: largest denomination not exceeding the given credit.
//   credit : current credit
//   code   : denomination code (vm_pkg COIN_*)
//   value  : value of that denomination
module change_picker
    import vm_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          code,
    output logic [CREDIT_W-1:0] value
);

    always_comb begin
        code  = credit >= CREDIT_W'(20) ? COIN_20 :
                credit >= CREDIT_W'(10) ? COIN_10 :
                credit >= CREDIT_W'(5)  ? COIN_5  : COIN_1;
        value = CREDIT_W'(coin_value(code));
    end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: credit accumulator with purchase, cancel and optional change payout.
//   clk, rst (sync, active high)
//   coin_valid/coin_type : coin insertion      buy_valid/buy_sel : purchase request
//   cancel               : refund request      coin              : registered credit
//   coin_reject, dispense_valid/dispense_item, buy_fail : one-cycle pulses
//   change_valid/change_type/busy : serial change train
//   Macro VM_CHANGE_EN enables the CHANGE state; without it cancel is ignored,
//   leftover credit is kept and the change outputs stay 0.
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int CREDIT_W    = 6,
    parameter int PRICE_CANDY = PRICE_CANDY_DEF,
    parameter int PRICE_DRINK = PRICE_DRINK_DEF,
    parameter int PRICE_SNACK = PRICE_SNACK_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                buy_valid,
    input  logic [1:0]          buy_sel,
    input  logic                cancel,
    output logic [CREDIT_W-1:0] coin,
    output logic                coin_reject,
    output logic                dispense_valid,
    output logic [1:0]          dispense_item,
    output logic                buy_fail,
    output logic                change_valid,
    output logic [1:0]          change_type,
    output logic                busy
);

    logic [CREDIT_W-1:0] credit, remain, pick_val;
    logic [CREDIT_W:0]   sum, price;
    logic [1:0]          pick_code;
    logic [0:0]          state;
    logic                coin_ok, can_buy;

`ifdef VM_CHANGE_EN
    localparam bit CHG_EN = 1'b1;
    change_picker #(.CREDIT_W(CREDIT_W)) u_pick (
        .credit(credit),
        .code  (pick_code),
        .value (pick_val)
    );
`else
    localparam bit CHG_EN = 1'b0;
    assign pick_code = COIN_1;
    assign pick_val  = '0;
`endif

    assign coin = credit;

    // One extra bit on sum/price so overflow and oversize prices are detected, never wrapped.
    always_comb begin
        sum     = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin_type));
        price   = buy_sel == ITEM_CANDY ? (CREDIT_W+1)'(PRICE_CANDY) :
                  buy_sel == ITEM_DRINK ? (CREDIT_W+1)'(PRICE_DRINK) : (CREDIT_W+1)'(PRICE_SNACK);
        coin_ok = !sum[CREDIT_W];
        can_buy = buy_sel != ITEM_NONE && {1'b0, credit} >= price;
        remain  = credit - price[CREDIT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            credit         <= '0;
            coin_reject    <= 1'b0;
            dispense_valid <= 1'b0;
            dispense_item  <= ITEM_NONE;
            buy_fail       <= 1'b0;
            change_valid   <= 1'b0;
            change_type    <= COIN_1;
            busy           <= 1'b0;
        end else begin
            coin_reject    <= 1'b0;
            dispense_valid <= 1'b0;
            dispense_item  <= ITEM_NONE;
            buy_fail       <= 1'b0;
            change_valid   <= 1'b0;
            change_type    <= COIN_1;
            busy           <= 1'b0;
            if (state == ST_CHANGE) begin
                credit       <= credit - pick_val;
                change_valid <= 1'b1;
                change_type  <= pick_code;
                busy         <= 1'b1;
                coin_reject  <= coin_valid;
                if (credit == pick_val) state <= ST_IDLE;
            end else if (CHG_EN && cancel) begin
                coin_reject <= coin_valid;
                if (credit != '0) state <= ST_CHANGE;
            end else if (buy_valid) begin
                coin_reject <= coin_valid;
                if (can_buy) begin
                    credit         <= remain;
                    dispense_valid <= 1'b1;
                    dispense_item  <= buy_sel;
                    if (CHG_EN && remain != '0) state <= ST_CHANGE;
                end else begin
                    buy_fail <= 1'b1;
                end
            end else if (coin_valid) begin
                if (coin_ok) credit <= sum[CREDIT_W-1:0];
                else coin_reject <= 1'b1;
            end
        end
    end

endmodule
